// File: rtl/sdram_frame_scheduler.sv
// Shares the SDRAM frame store between one frame writer and one frame reader.
// Computes the frame size by shift-add, drives the controller address window and rewinds it before every phase.
module sdram_frame_scheduler #(
    parameter int ADDR_W      = 23,
    parameter int DIM_W       = 16,
    parameter int LOAD_CYCLES = 4,
    parameter int OVERWRITE   = 0
) (
    input  logic              clock_50,
    input  logic              reset_n,
    input  logic              cfg_valid,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic              cfg_ready,
    output logic              cfg_error,
    input  logic              wr_req,
    output logic              wr_grant,
    input  logic              wr_frame_done,
    input  logic              rd_req,
    output logic              rd_grant,
    input  logic              rd_frame_done,
    output logic              load,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] max_addr1,
    output logic [ADDR_W-1:0] max_addr2,
    output logic              frame_avail
);

    localparam int   P_W      = 2 * DIM_W;
    localparam int   CNT_W    = $clog2(DIM_W + 1);
    localparam int   LC_W     = $clog2(LOAD_CYCLES + 1);
    localparam logic OVW_BIT  = (OVERWRITE != 0);

    typedef enum logic [2:0] {IDLE, MULT, LOAD, ARB, WRITE, READ} state_t;

    state_t            state;
    logic [CNT_W-1:0]  mcnt;
    logic [LC_W-1:0]   lcnt;
    logic [P_W-1:0]    acc;
    logic [P_W-1:0]    mcand;
    logic [DIM_W-1:0]  mplier;
    logic              from_arb;
    logic              last_writer;

    logic [P_W-1:0]    step_sum;
    logic              too_big;
    logic [ADDR_W-2:0] size;
    logic              wr_elig;
    logic              rd_elig;

    // The final multiply step is evaluated combinationally so the addresses land on the last MULT edge.
    always_comb begin
        step_sum = acc + (mplier[0] ? mcand : '0);
        too_big  = (step_sum >> (ADDR_W - 1)) != '0;
        size     = step_sum[ADDR_W-2:0];
        wr_elig  = wr_req & (~frame_avail | OVW_BIT);
        rd_elig  = rd_req & frame_avail;
    end

    assign addr1 = '0;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            load        <= 1'b1;
            cfg_ready   <= 1'b0;
            cfg_error   <= 1'b0;
            wr_grant    <= 1'b0;
            rd_grant    <= 1'b0;
            frame_avail <= 1'b0;
            addr2       <= '0;
            max_addr1   <= '0;
            max_addr2   <= '0;
            mcnt        <= '0;
            lcnt        <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            from_arb    <= 1'b0;
            last_writer <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    load <= 1'b0;
                    if (cfg_ready && cfg_valid) begin
                        state     <= MULT;
                        cfg_ready <= 1'b0;
                        cfg_error <= 1'b0;
                        acc       <= '0;
                        mcand     <= P_W'(width);
                        mplier    <= height;
                        mcnt      <= '0;
                        from_arb  <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                MULT: begin
                    acc    <= step_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mcnt   <= mcnt + CNT_W'(1);
                    if (mcnt == CNT_W'(DIM_W - 1)) begin
                        if (step_sum == '0 || too_big) begin
                            cfg_error <= 1'b1;
                            cfg_ready <= 1'b1;
                            state     <= from_arb ? ARB : IDLE;
                        end else begin
                            addr2       <= {1'b0, size};
                            max_addr1   <= {1'b0, size};
                            max_addr2   <= {size, 1'b0};
                            frame_avail <= 1'b0;
                            load        <= 1'b1;
                            lcnt        <= '0;
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (lcnt == LC_W'(LOAD_CYCLES - 1)) begin
                        load      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state     <= ARB;
                    end else begin
                        lcnt <= lcnt + LC_W'(1);
                    end
                end
                ARB: begin
                    if (cfg_ready && cfg_valid) begin
                        state     <= MULT;
                        cfg_ready <= 1'b0;
                        cfg_error <= 1'b0;
                        acc       <= '0;
                        mcand     <= P_W'(width);
                        mplier    <= height;
                        mcnt      <= '0;
                        from_arb  <= 1'b1;
                    end else if (rd_elig && (!wr_elig || last_writer)) begin
                        rd_grant    <= 1'b1;
                        last_writer <= 1'b0;
                        cfg_ready   <= 1'b0;
                        state       <= READ;
                    end else if (wr_elig) begin
                        wr_grant    <= 1'b1;
                        last_writer <= 1'b1;
                        cfg_ready   <= 1'b0;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_frame_done) begin
                        wr_grant    <= 1'b0;
                        frame_avail <= 1'b1;
                        load        <= 1'b1;
                        lcnt        <= '0;
                        state       <= LOAD;
                    end
                end
                READ: begin
                    if (rd_frame_done) begin
                        rd_grant    <= 1'b0;
                        frame_avail <= 1'b0;
                        load        <= 1'b1;
                        lcnt        <= '0;
                        state       <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
